// File: rtl/adpcm_a_bus_master.sv
// adpcm_a_bus_master: YM2610 ADPCM-A sample-ROM bus initiator with parameterised phase timing.
module adpcm_a_bus_master #(
    parameter int T_LO   = 16,
    parameter int T_HI   = 16,
    parameter int T_TA   = 1,
    parameter int T_DATA = 32,
    parameter int T_REC  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic [7:0]  rad_out,
    output logic        rad_oe,
    input  logic [7:0]  rad_in,
    output logic [1:0]  ra_9_8,
    output logic [3:0]  ra_23_20,
    output logic        rmpx,
    output logic        roe_n,
    output logic [15:0] txn_count
);
    typedef enum logic [2:0] {IDLE, SETUP, LO, HI, TA, DATA, REC} state_t;
    localparam logic [7:0] N_LO   = 8'(T_LO - 1);
    localparam logic [7:0] N_HI   = 8'(T_HI - 1);
    localparam logic [7:0] N_TA   = 8'(T_TA - 1);
    localparam logic [7:0] N_DATA = 8'(T_DATA - 1);
    localparam logic [7:0] N_REC  = 8'(T_REC - 1);
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d, load;
    logic [23:0] addr_q, addr_d;
    logic rmpx_q, rmpx_d, roe_n_q, roe_n_d, rad_oe_q, rad_oe_d, rsp_valid_q, rsp_valid_d;
    logic [7:0] rad_out_q, rad_out_d, rsp_data_q, rsp_data_d;
    logic [1:0] ra_9_8_q, ra_9_8_d;
    logic [3:0] ra_23_20_q, ra_23_20_d;
    logic [15:0] txn_count_q, txn_count_d;
    logic done, capture, addr_ph, hi_ph;
    assign req_ready = state_q == IDLE && !reset;
    always_comb begin
        done = cnt_q == 8'd0;
        state_d = state_q;
        addr_d = addr_q;
        case (state_q)
            IDLE:    if (req_valid && req_ready) begin state_d = SETUP; addr_d = req_addr; end
            SETUP:   state_d = LO;
            LO:      if (done) state_d = HI;
            HI:      if (done) state_d = TA;
            TA:      if (done) state_d = DATA;
            DATA:    if (done) state_d = REC;
            REC:     if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // each timed state is entered with its length minus one and left when the count hits zero
        load = state_d == LO ? N_LO : state_d == HI ? N_HI : state_d == TA ? N_TA :
               state_d == DATA ? N_DATA : state_d == REC ? N_REC : 8'd0;
        cnt_d = state_d != state_q ? load : done ? 8'd0 : cnt_q - 8'd1;
        capture = state_q == DATA && done;
        addr_ph = state_d == SETUP || state_d == LO;
        hi_ph = state_d == HI || state_d == TA;
        rmpx_d = state_d == LO;
        roe_n_d = state_d != DATA;
        rad_oe_d = addr_ph || state_d == HI;
        rad_out_d = addr_ph ? addr_d[7:0] : state_d == HI ? addr_d[17:10] : 8'd0;
        ra_9_8_d = addr_ph ? addr_d[9:8] : hi_ph ? addr_d[19:18] : 2'd0;
        ra_23_20_d = hi_ph ? addr_d[23:20] : 4'd0;
        rsp_valid_d = capture;
        rsp_data_d = capture ? rad_in : rsp_data_q;
        txn_count_d = txn_count_q + {15'd0, capture};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= 8'd0;
            addr_q <= 24'd0;
            rmpx_q <= 1'b0;
            roe_n_q <= 1'b1;
            rad_oe_q <= 1'b0;
            rad_out_q <= 8'd0;
            ra_9_8_q <= 2'd0;
            ra_23_20_q <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q <= 8'd0;
            txn_count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            rmpx_q <= rmpx_d;
            roe_n_q <= roe_n_d;
            rad_oe_q <= rad_oe_d;
            rad_out_q <= rad_out_d;
            ra_9_8_q <= ra_9_8_d;
            ra_23_20_q <= ra_23_20_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q <= rsp_data_d;
            txn_count_q <= txn_count_d;
        end
    end
    assign rmpx = rmpx_q;
    assign roe_n = roe_n_q;
    assign rad_oe = rad_oe_q;
    assign rad_out = rad_out_q;
    assign ra_9_8 = ra_9_8_q;
    assign ra_23_20 = ra_23_20_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data = rsp_data_q;
    assign txn_count = txn_count_q;
endmodule
